// File: rtl/kbd_pkg.sv
// Shared PS/2 keyboard definitions: host-transmit FSM states, frame length,
// common command bytes and the PS/2 parity helper.
package kbd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StInhibit,
    StReq,
    StXfer
  } kbd_tx_state_e;

  // Falling edges in one host-to-device frame, including the ACK edge.
  localparam int unsigned PS2_FRAME_EDGES = 11;

  localparam logic [7:0] KBD_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] KBD_CMD_RESET    = 8'hFF;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~(^b);
  endfunction

endpackage

// File: rtl/ps2_falling_edge.sv
// Filtered PS/2 clock falling-edge detector, shared by the host transmitter
// and the keyboard receiver. An edge is reported only after four high samples
// followed by four low samples, which rejects short glitches on the line.
module ps2_falling_edge (
  input  logic clk,
  input  logic reset,
  input  logic ps2clk_i,
  output logic fall_o
);

  logic [7:0] hist_q, hist_d;

  // Shift the newest sample into the LSB; older samples move toward the MSB.
  always_comb begin
    hist_d = {hist_q[6:0], ps2clk_i};
  end

  // Sample history register.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign fall_o = (hist_q == 8'hF0);

endmodule

// File: rtl/kbd_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request to
// send, then shifts out cmd, odd parity and stop on device clock falling
// edges and checks the device ACK.
// Optional build macro KBD_TX_TIMEOUT_EN adds a watchdog on device clock
// edges while in REQ and XFER.
module kbd_host_tx
  import kbd_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  input  logic       send,
  input  logic [7:0] cmd,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // One counter serves both the inhibit interval and the watchdog, so it is
  // sized for whichever interval is longer.
  localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                   INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CntW = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYCLES - 1);
  localparam logic [3:0] AckEdgeCnt = 4'(PS2_FRAME_EDGES - 1);
`ifdef KBD_TX_TIMEOUT_EN
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
`endif

  kbd_tx_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      edge_q, edge_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic            clk_oe_q, clk_oe_d;
  logic            data_oe_q, data_oe_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            fall;

  ps2_falling_edge u_fall (
    .clk      (clk),
    .reset    (reset),
    .ps2clk_i (ps2clk),
    .fall_o   (fall)
  );

  // Next-state logic for the transmit FSM and its line drivers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (send) begin
          shift_d   = cmd;
          parity_d  = odd_parity(cmd);
          cnt_d     = '0;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          state_d   = StInhibit;
        end
      end
      StInhibit: begin
        if (cnt_q == InhibitLast) begin
          cnt_d     = '0;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;  // start bit
          state_d   = StReq;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReq: begin
        if (fall) begin
          edge_d    = 4'd1;
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          state_d   = StXfer;
        end
      end
      StXfer: begin
        if (fall) begin
          edge_d = edge_q + 4'd1;
          if (edge_q < 4'd8) begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end else if (edge_q == 4'd8) begin
            data_oe_d = ~parity_q;
          end else if (edge_q == 4'd9) begin
            data_oe_d = 1'b0;  // stop bit: release the line
          end else if (edge_q == AckEdgeCnt) begin
            // Device pulls data low to acknowledge.
            done_d    = ~ps2data;
            err_d     = ps2data;
            edge_d    = '0;
            data_oe_d = 1'b0;
            clk_oe_d  = 1'b0;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef KBD_TX_TIMEOUT_EN
    // Watchdog: restart on every device edge, abort when edges stop.
    if (state_q == StReq || state_q == StXfer) begin
      if (fall) begin
        cnt_d = '0;
      end else if (cnt_q == TimeoutLast) begin
        err_d     = 1'b1;
        done_d    = 1'b0;
        edge_d    = '0;
        cnt_d     = '0;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = StIdle;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      edge_q    <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ps2clk_oe  = clk_oe_q;
  assign ps2data_oe = data_oe_q;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_kbd_host_tx.sv
// Bench for kbd_host_tx: a PS/2 device model clocks frames out of the host,
// expected frames and outcomes go into a scoreboard queue, and a monitor
// checks them whenever done or err pulses.
module tb_kbd_host_tx;
  import kbd_pkg::*;

  localparam int unsigned InhibitCycles = 5000;
  localparam int unsigned TimeoutCycles = 1000;

  logic       clk = 1'b0;
  logic       reset;
  logic       send;
  logic [7:0] cmd;
  logic       ps2clk, ps2data;
  logic       ps2clk_oe, ps2data_oe;
  logic       busy, done, err;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  // Open-drain bus: either side may pull low.
  assign ps2clk  = dev_clk & ~ps2clk_oe;
  assign ps2data = dev_data & ~ps2data_oe;

  kbd_host_tx #(
    .INHIBIT_CYCLES (InhibitCycles),
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2clk     (ps2clk),
    .ps2data    (ps2data),
    .ps2clk_oe  (ps2clk_oe),
    .ps2data_oe (ps2data_oe),
    .send       (send),
    .cmd        (cmd),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] frame;
    bit          chk_frame;
    bit          exp_done;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [10:0] cap_frame;
  int          checks = 0;
  int          failures = 0;
  int          done_seen = 0;
  int          err_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done/err pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (done || err) begin
      check("done_err_exclusive", 32'(done & err), 32'd0);
      check("busy_low_on_pulse", 32'(busy), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: done=%0b err=%0b, expected no pulse", done, err);
      end else begin
        mon_e = sb.pop_front();
        check("outcome_done", 32'(done), 32'(mon_e.exp_done));
        check("outcome_err", 32'(err), 32'(!mon_e.exp_done));
        if (mon_e.chk_frame) check("frame_bits", 32'(cap_frame), 32'(mon_e.frame));
      end
      if (done) done_seen++;
      if (err) err_seen++;
    end
  end

  task automatic do_send(input logic [7:0] c);
    @(negedge clk);
    send = 1'b1;
    cmd  = c;
    @(negedge clk);
    send = 1'b0;
    check("busy_after_send", 32'(busy), 32'd1);
  endtask

  // Device model: waits for request-to-send, then generates n_edges clocks,
  // capturing the line on each rising edge; optionally ACKs on edge 11.
  task automatic run_device(input int n_edges, input bit ack);
    int t;
    t = 0;
    cap_frame = '0;
    while (!(ps2data_oe && !ps2clk_oe) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) begin
      checks++;
      failures++;
      $display("FAIL req_wait: no request-to-send after %0d cycles, expected one", t);
      return;
    end
    repeat (10) @(negedge clk);
    cap_frame[0] = ps2data;
    for (int i = 1; i <= n_edges; i++) begin
      if (i == 11 && ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      if (i <= 10) cap_frame[i] = ps2data;
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      repeat (20) @(negedge clk);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int exp_errs;
    reset = 1'b1;
    send  = 1'b0;
    cmd   = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_clk_oe", 32'(ps2clk_oe), 32'd0);
    check("rst_data_oe", 32'(ps2data_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Device clocks while idle must be ignored.
    for (int i = 0; i < 3; i++) begin
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
      repeat (20) @(negedge clk);
    end
    check("idle_edges_busy", 32'(busy), 32'd0);
    check("idle_edges_clk_oe", 32'(ps2clk_oe), 32'd0);
    check("idle_edges_data_oe", 32'(ps2data_oe), 32'd0);

    // 0xED, ACKed: {stop, parity=1, ED, start} = 11'h7DA. Also time the inhibit.
    sb.push_back('{11'h7DA, 1'b1, 1'b1});
    do_send(KBD_CMD_SET_LEDS);
    n = 0;
    while (ps2clk_oe && n < 6000) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_len", 32'(n), 32'(InhibitCycles));
    check("req_data_oe", 32'(ps2data_oe), 32'd1);
    check("req_clk_oe", 32'(ps2clk_oe), 32'd0);
    run_device(11, 1'b1);
    check("busy_after_frame", 32'(busy), 32'd0);

    // 0xA5 with a second send mid-frame that must be ignored: 11'h74A.
    sb.push_back('{11'h74A, 1'b1, 1'b1});
    do_send(8'hA5);
    fork
      run_device(11, 1'b1);
      begin
        repeat (5200) @(negedge clk);
        check("busy_mid_frame", 32'(busy), 32'd1);
        send = 1'b1;
        cmd  = 8'h3C;
        @(negedge clk);
        send = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    check("second_send_dropped", 32'(busy), 32'd0);

    // 0x07 has three ones, so parity is 0: 11'h40E.
    sb.push_back('{11'h40E, 1'b1, 1'b1});
    do_send(8'h07);
    run_device(11, 1'b1);

    // 0x00 with no ACK: parity 1, frame 11'h600, err expected.
    sb.push_back('{11'h600, 1'b1, 1'b0});
    do_send(8'h00);
    run_device(11, 1'b0);
    repeat (10) @(negedge clk);

    // Reset after edge 4: lines released next cycle, no pulse.
    do_send(8'h5A);
    run_device(4, 1'b1);
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_clk_oe", 32'(ps2clk_oe), 32'd0);
    check("midrst_data_oe", 32'(ps2data_oe), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (50) @(negedge clk);

    exp_errs = 1;
`ifdef KBD_TX_TIMEOUT_EN
    // Silent device: err exactly TimeoutCycles cycles after entering REQ.
    exp_errs = 2;
    sb.push_back('{11'h000, 1'b0, 1'b0});
    do_send(KBD_CMD_RESET);
    n = 0;
    while (!ps2data_oe && n < 20000) begin
      n++;
      @(negedge clk);
    end
    n = 0;
    while (!err && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check("timeout_len", 32'(n), 32'(TimeoutCycles));
    check("timeout_clk_oe", 32'(ps2clk_oe), 32'd0);
    check("timeout_data_oe", 32'(ps2data_oe), 32'd0);
    repeat (10) @(negedge clk);
`endif

    repeat (20) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("done_count", 32'(done_seen), 32'd3);
    check("err_count", 32'(err_seen), 32'(exp_errs));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kbd_host_tx.md
KBD_HOST_TX -- requirements
Module: kbd_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, clk cycles ps2clk is held low before the request (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, maximum clk cycles allowed between device clock edges (20 ms at 50 MHz).
REQ-003 SHALL have port clk, input, 1, system clock, the only clock.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port ps2clk, input, 1, PS/2 clock line as read back from the pad.
REQ-006 SHALL have port ps2data, input, 1, PS/2 data line as read back from the pad.
REQ-007 SHALL have port ps2clk_oe, output, 1, 1 = drive ps2clk low; 0 = release it.
REQ-008 SHALL have port ps2data_oe, output, 1, 1 = drive ps2data low; 0 = release it.
REQ-009 SHALL have port send, input, 1, single-cycle request to transmit cmd.
REQ-010 SHALL have port cmd, input, 8, host-to-device byte (e.g. 8'hED set LEDs, 8'hFF reset).
REQ-011 SHALL have port busy, output, 1, high from the cycle after an accepted send until return to IDLE.
REQ-012 SHALL have port done, output, 1, one-cycle pulse on acknowledged completion.
REQ-013 SHALL have port err, output, 1, one-cycle pulse on missing ACK or timeout.

Function
REQ-014 SHALL detect a device clock falling edge when the last 8 ps2clk samples are 4'hF followed by 4'h0 (older samples 1s, newer samples 0s).
REQ-015 SHALL accept send only in IDLE: it latches cmd, computes odd parity, and enters INHIBIT on the next cycle; send while busy SHALL be ignored.
REQ-016 INHIBIT SHALL hold ps2clk_oe=1 and ps2data_oe=0 for exactly INHIBIT_CYCLES cycles, then enter REQ.
REQ-017 REQ SHALL hold ps2data_oe=1 (start bit 0) and ps2clk_oe=0; the first detected falling edge SHALL enter XFER with edge count 1.
REQ-018 At falling edges 1..8 of XFER, ps2data_oe SHALL become the inverse of cmd[edge-1] (LSB first).
REQ-019 At falling edge 9, ps2data_oe SHALL become the inverse of odd parity; at edge 10 it SHALL become 0 (stop bit, line released).
REQ-020 At edge 11, the block SHALL sample ps2data: 0 → done pulse; 1 → err pulse; either outcome returns to IDLE.
REQ-021 Ignoring falling edges in IDLE and INHIBIT SHALL not disturb state.
REQ-022 done and err SHALL never be asserted in the same cycle; busy SHALL drop in the same cycle as the done or err pulse.
REQ-023 States SHALL be IDLE, INHIBIT, REQ, XFER; no other state is reachable.

Reset
REQ-024 On reset, the state SHALL be IDLE; ps2clk_oe, ps2data_oe, busy, done and err SHALL be 0; sample history, counters, shift register and parity SHALL be 0.
REQ-025 Reset asserted mid-transfer SHALL release both lines on the next clk edge and discard the command with no done or err pulse.

Configuration
REQ-026 With KBD_TX_TIMEOUT_EN defined, a watchdog SHALL be active in REQ and XFER: it clears on each falling edge and pulses err, releases both lines and returns to IDLE after TIMEOUT_CYCLES cycles with no edge.
REQ-027 Without KBD_TX_TIMEOUT_EN, no watchdog logic SHALL exist and the block SHALL wait indefinitely for device clocks.

Structure
REQ-028 Package kbd_pkg SHALL hold the state enum, PS2_FRAME_EDGES=11, and command constants KBD_CMD_SET_LEDS=8'hED, KBD_CMD_RESET=8'hFF.
REQ-029 Sub-module ps2_falling_edge (8-sample shift register plus edge decode) SHALL be factored out so it is shared with the keyboard receiver.

Verification
REQ-030 send with cmd=8'hED and a device model generating 11 clocks with ACK → line bits 0,1,0,1,1,0,1,1,1,1(parity),1; done pulse; busy=0.
REQ-031 INHIBIT_CYCLES=5000, send → ps2clk_oe high for exactly 5000 cycles, then ps2data_oe=1 with ps2clk_oe=0.
REQ-032 cmd=8'h00 and a device holding data high at edge 11 → parity bit 1; err pulse; no done pulse.
REQ-033 With KBD_TX_TIMEOUT_EN, TIMEOUT_CYCLES=1000 and a silent device → err exactly 1000 cycles after entering REQ; lines released.
REQ-034 reset asserted after edge 4 → next cycle ps2clk_oe=0, ps2data_oe=0, busy=0; no done or err pulse.
REQ-035 Second send during a transfer → ignored; the frame carries the first cmd only.
